// File: rtl/ddc_pkg.sv
// Shared definitions for the digital down-converter datapath.
//
// Contents:
//   DefPhaseWidth / DefAddrWidth / DefRomLatency - default widths and ROM latency
//   quadrant_e    - quadrant of a phase word (top two bits)
//   quad_advance  - quadrant shifted by +90 degrees (sine -> cosine)
//   quad_mirror   - quadrant reads the quarter-wave table backwards
//   quad_negate   - quadrant takes the negated table value
package ddc_pkg;

    localparam int unsigned DefPhaseWidth = 32;
    localparam int unsigned DefAddrWidth  = 10;
    localparam int unsigned DefRomLatency = 1;

    typedef enum logic [1:0] {
        QuadI   = 2'd0,
        QuadII  = 2'd1,
        QuadIII = 2'd2,
        QuadIV  = 2'd3
    } quadrant_e;

    // cos(x) = sin(x + 90deg): cosine uses the next quadrant, wrapping IV -> I.
    function automatic quadrant_e quad_advance(input quadrant_e q);
        logic [1:0] v;
        v = q;
        v = v + 2'd1;
        return quadrant_e'(v);
    endfunction

    // Quadrants II and IV walk the quarter-wave table from the top down.
    function automatic logic quad_mirror(input quadrant_e q);
        return (q == QuadII) || (q == QuadIV);
    endfunction

    // Quadrants III and IV lie in the negative half of the wave.
    function automatic logic quad_negate(input quadrant_e q);
        return (q == QuadIII) || (q == QuadIV);
    endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-length shift register with synchronous active-high reset.
//
// Parameters:
//   WIDTH - bits per stage
//   DEPTH - number of register stages (latency in cycles), >= 1
// Ports:
//   clk_i - clock, rising edge
//   rst_i - synchronous active-high reset, clears every stage
//   d_i   - data in
//   q_o   - data out, d_i delayed by DEPTH cycles
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/nco_addr_gen.sv
// Numerically controlled oscillator front end: phase accumulator plus
// quarter-wave ROM address generation for sine and cosine.
//
// Parameters:
//   PHASE_WIDTH - accumulator / tuning word width
//   ADDR_WIDTH  - quarter-wave ROM address width (PHASE_WIDTH >= ADDR_WIDTH + 2)
//   ROM_LATENCY - read latency of the downstream ROM in cycles (>= 1)
// Ports:
//   clk_i       - clock, rising edge
//   rst_i       - synchronous active-high reset
//   en_i        - sample enable, advances accumulator and pipeline
//   ftw_i       - frequency tuning word
//   ftw_load_i  - capture ftw_i into the tuning register
//   phase_off_i - static phase offset added after the accumulator
//   sync_i      - clears the accumulator (wins over accumulation)
//   rom_en_o    - ROM read enable, en_i delayed one cycle
//   addr_sin_o  - sine ROM address
//   addr_cos_o  - cosine ROM address
//   neg_sin_o   - negate flag for sine ROM data, aligned with the data
//   neg_cos_o   - negate flag for cosine ROM data, aligned with the data
//   valid_o     - ROM data and negate flags valid this cycle
module nco_addr_gen
    import ddc_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = DefPhaseWidth,
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned ROM_LATENCY = DefRomLatency
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [PHASE_WIDTH-1:0] ftw_i,
    input  logic                   ftw_load_i,
    input  logic [PHASE_WIDTH-1:0] phase_off_i,
    input  logic                   sync_i,
    output logic                   rom_en_o,
    output logic [ADDR_WIDTH-1:0]  addr_sin_o,
    output logic [ADDR_WIDTH-1:0]  addr_cos_o,
    output logic                   neg_sin_o,
    output logic                   neg_cos_o,
    output logic                   valid_o
);

    if (ROM_LATENCY < 1) begin : gen_bad_latency
        $error("nco_addr_gen: ROM_LATENCY must be at least 1");
    end
    if (PHASE_WIDTH < ADDR_WIDTH + 2) begin : gen_bad_width
        $error("nco_addr_gen: PHASE_WIDTH must be at least ADDR_WIDTH + 2");
    end

    logic [PHASE_WIDTH-1:0] ftw_q;
    logic [PHASE_WIDTH-1:0] acc_q;
    logic [PHASE_WIDTH-1:0] phase_d;

    quadrant_e              quad_sin;
    quadrant_e              quad_cos;
    logic [ADDR_WIDTH-1:0]  idx;
    logic [ADDR_WIDTH-1:0]  addr_sin_d;
    logic [ADDR_WIDTH-1:0]  addr_cos_d;
    logic                   neg_sin_d;
    logic                   neg_cos_d;

    // The phase register is held in decoded form (addresses + negate flags),
    // so a reset leaves every ROM-facing output at zero.
    logic                   rom_en_q;
    logic [ADDR_WIDTH-1:0]  addr_sin_q;
    logic [ADDR_WIDTH-1:0]  addr_cos_q;
    logic                   neg_sin_q;
    logic                   neg_cos_q;

    logic [2:0]             dly_in;
    logic [2:0]             dly_out;
    logic                   unused_phase;

    // Tuning word: a load in the same cycle as en_i only affects later samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ftw_q <= '0;
        end else if (ftw_load_i) begin
            ftw_q <= ftw_i;
        end
    end

    // Accumulator wraps naturally; sync clears it after the current sample
    // has already taken the pre-sync value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (sync_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + ftw_q;
        end
    end

    assign phase_d = acc_q + phase_off_i;

    // Bits below the address field are truncated; the reduction only marks
    // them as intentionally dropped.
    assign unused_phase = ^phase_d;

    always_comb begin
        quad_sin   = quadrant_e'(phase_d[PHASE_WIDTH-1 -: 2]);
        idx        = phase_d[PHASE_WIDTH-3 -: ADDR_WIDTH];
        quad_cos   = quad_advance(quad_sin);
        addr_sin_d = quad_mirror(quad_sin) ? ~idx : idx;
        addr_cos_d = quad_mirror(quad_cos) ? ~idx : idx;
        neg_sin_d  = quad_negate(quad_sin);
        neg_cos_d  = quad_negate(quad_cos);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rom_en_q   <= 1'b0;
            addr_sin_q <= '0;
            addr_cos_q <= '0;
            neg_sin_q  <= 1'b0;
            neg_cos_q  <= 1'b0;
        end else begin
            rom_en_q <= en_i;
            if (en_i) begin
                addr_sin_q <= addr_sin_d;
                addr_cos_q <= addr_cos_d;
                neg_sin_q  <= neg_sin_d;
                neg_cos_q  <= neg_cos_d;
            end
        end
    end

    // rom_en_q doubles as the per-sample valid token; it travels with the
    // negate flags so they line up with the ROM read data.
    assign dly_in = {rom_en_q, neg_sin_q, neg_cos_q};

    delay_line #(
        .WIDTH (3),
        .DEPTH (ROM_LATENCY)
    ) u_flag_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (dly_in),
        .q_o   (dly_out)
    );

    assign rom_en_o   = rom_en_q;
    assign addr_sin_o = addr_sin_q;
    assign addr_cos_o = addr_cos_q;
    assign valid_o    = dly_out[2];
    assign neg_sin_o  = dly_out[1];
    assign neg_cos_o  = dly_out[0];

endmodule

// File: tb/tb_nco_addr_gen.sv
module tb_nco_addr_gen;

    typedef struct {
        logic        rst;
        logic        en;
        logic        sync;
        logic        ld;
        logic [31:0] ftw;
        logic [31:0] off;
        logic        ren;
        logic [9:0]  asin;
        logic [9:0]  acos;
        logic        nsin;
        logic        ncos;
        logic        vld;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] ftw;
    logic        ftw_load;
    logic [31:0] phase_off;
    logic        sync;
    logic        rom_en;
    logic [9:0]  addr_sin;
    logic [9:0]  addr_cos;
    logic        neg_sin;
    logic        neg_cos;
    logic        valid;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    nco_addr_gen #(
        .PHASE_WIDTH (32),
        .ADDR_WIDTH  (10),
        .ROM_LATENCY (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .ftw_i       (ftw),
        .ftw_load_i  (ftw_load),
        .phase_off_i (phase_off),
        .sync_i      (sync),
        .rom_en_o    (rom_en),
        .addr_sin_o  (addr_sin),
        .addr_cos_o  (addr_cos),
        .neg_sin_o   (neg_sin),
        .neg_cos_o   (neg_cos),
        .valid_o     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic s, input logic l,
                       input logic [31:0] f, input logic [31:0] o, input logic ren,
                       input int as, input int ac, input logic ns, input logic nc,
                       input logic v);
        vec_t t;
        t.rst  = r;
        t.en   = e;
        t.sync = s;
        t.ld   = l;
        t.ftw  = f;
        t.off  = o;
        t.ren  = ren;
        t.asin = 10'(as);
        t.acos = 10'(ac);
        t.nsin = ns;
        t.ncos = nc;
        t.vld  = v;
        vq.push_back(t);
    endtask

    initial begin
        int cnt;
        int pos;
        logic [31:0] got_w;
        logic [31:0] exp_w;

        rst       = 1'b0;
        en        = 1'b0;
        ftw       = '0;
        ftw_load  = 1'b0;
        phase_off = '0;
        sync      = 1'b0;

        // Expected outputs are those seen after the edge that applied the row.
        //   rst en sy ld ftw            off            ren asin acos ns nc v
        // reset
        add(1, 0, 0, 0, 32'h0,         32'h0,         0, 0,    0,    0, 0, 0);
        // quarter step
        add(0, 0, 0, 1, 32'h4000_0000, 32'h0,         0, 0,    0,    0, 0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 0, 0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 1023, 0,    0, 0, 1);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 0, 1, 1);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 1023, 0,    1, 1, 1);
        add(0, 0, 0, 0, 32'h0,         32'h0,         0, 1023, 0,    1, 0, 1);
        add(0, 0, 0, 0, 32'h0,         32'h0,         0, 1023, 0,    1, 0, 0);
        // half step wrap
        add(0, 0, 0, 1, 32'h8000_0000, 32'h0,         0, 1023, 0,    1, 0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 1, 0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 0, 0, 1);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 1, 1, 1);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 0, 0, 1);
        add(0, 0, 0, 0, 32'h0,         32'h0,         0, 0,    1023, 1, 1, 1);
        // static offset, ftw 0
        add(0, 0, 0, 1, 32'h0,         32'h2000_0000, 0, 0,    1023, 1, 1, 0);
        add(0, 1, 0, 0, 32'h0,         32'h2000_0000, 1, 512,  511,  1, 1, 0);
        add(0, 1, 0, 0, 32'h0,         32'h2000_0000, 1, 512,  511,  0, 0, 1);
        add(0, 1, 0, 0, 32'h0,         32'h2000_0000, 1, 512,  511,  0, 0, 1);
        add(0, 0, 0, 0, 32'h0,         32'h0,         0, 512,  511,  0, 0, 1);
        // sync after five samples
        add(0, 0, 1, 1, 32'h0100_0000, 32'h0,         0, 512,  511,  0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            add(0, 1, 0, 0, 32'h0,     32'h0,         1, 16 * k, 1023 - 16 * k, 0, 0, k != 0);
        end
        add(0, 1, 1, 0, 32'h0,         32'h0,         1, 80,   943,  0, 0, 1);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 0, 0, 1);
        add(0, 0, 0, 0, 32'h0,         32'h0,         0, 0,    1023, 0, 0, 1);
        // en gating 1,0,1 with held addresses
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 16,   1007, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,         32'h0,         0, 16,   1007, 0, 0, 1);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 32,   991,  0, 0, 0);
        add(0, 0, 0, 0, 32'h0,         32'h0,         0, 32,   991,  0, 0, 1);
        // reset mid-run, ftw_q cleared until reloaded
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 48,   975,  0, 0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 64,   959,  0, 0, 1);
        add(1, 1, 0, 0, 32'h0,         32'h0,         0, 0,    0,    0, 0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 0, 0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 0, 0, 1);
        // load together with en: this sample still uses the old ftw
        add(0, 1, 0, 1, 32'h4000_0000, 32'h0,         1, 0,    1023, 0, 0, 1);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 0, 0, 1);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 1023, 0,    0, 0, 1);
        add(0, 0, 0, 0, 32'h0,         32'h0,         0, 1023, 0,    0, 1, 1);
        // reset beats load, sync and en
        add(1, 1, 1, 1, 32'h4000_0000, 32'h0,         0, 0,    0,    0, 0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 0, 0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 0,    1023, 0, 0, 1);

        for (int k = 0; k < vq.size(); k++) begin
            rst       = vq[k].rst;
            en        = vq[k].en;
            sync      = vq[k].sync;
            ftw_load  = vq[k].ld;
            ftw       = vq[k].ftw;
            phase_off = vq[k].off;
            @(posedge clk);
            @(negedge clk);
            got_w = {8'h0, rom_en, addr_sin, addr_cos, neg_sin, neg_cos, valid};
            exp_w = {8'h0, vq[k].ren, vq[k].asin, vq[k].acos, vq[k].nsin, vq[k].ncos,
                     vq[k].vld};
            check($sformatf("vec%0d {ren,asin,acos,nsin,ncos,vld}", k), got_w, exp_w);
        end

        // Single isolated sample: exactly one valid, two cycles after en.
        rst      = 1'b0;
        en       = 1'b0;
        sync     = 1'b0;
        ftw_load = 1'b0;
        repeat (3) @(negedge clk);
        check("drained valid", {31'h0, valid}, 32'h0);
        en  = 1'b1;
        cnt = 0;
        pos = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            en = 1'b0;
            if (c == 1) check("single rom_en", {31'h0, rom_en}, 32'h1);
            if (valid) begin
                cnt++;
                pos = c;
            end
        end
        check("single valid count", 32'(cnt), 32'd1);
        check("single valid cycle", 32'(pos), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
